// File: rtl/piso_byte_serializer.sv
// Parallel-in / serial-out byte serializer.
// Takes a word of up to WORD_BYTES bytes over valid/ready and streams it out one
// byte per clock with first/last markers. The next word is taken on the cycle the
// last byte of the current word is on the output, so back-to-back words have no gap.
module piso_byte_serializer #(
  parameter int                  DATA_WID   = 8,
  parameter int                  WORD_BYTES = 4,
  parameter bit                  MSB_FIRST  = 1'b1,
  parameter logic [DATA_WID-1:0] IDLE_BYTE  = 8'h00
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clr,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [DATA_WID*WORD_BYTES-1:0] i_in_data,
  input  logic [$clog2(WORD_BYTES+1)-1:0] i_in_nbytes,
  output logic [DATA_WID-1:0]            o_ser_data,
  output logic                           o_ser_valid,
  output logic                           o_ser_first,
  output logic                           o_ser_last,
  output logic                           o_busy
);

  localparam int NB_W   = $clog2(WORD_BYTES + 1);
  localparam int WORD_W = DATA_WID * WORD_BYTES;

  localparam logic [NB_W-1:0]   CNT_ZERO  = {NB_W{1'b0}};
  localparam logic [NB_W-1:0]   CNT_ONE   = {{(NB_W-1){1'b0}}, 1'b1};
  localparam logic [NB_W-1:0]   CNT_TWO   = CNT_ONE << 1;
  localparam logic [NB_W-1:0]   CNT_FULL  = NB_W'(WORD_BYTES);
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [NB_W-1:0]     r_cnt;      // bytes still to show, including the one on the output
  logic [WORD_W-1:0]   r_shreg;    // remaining bytes in send order, next byte in lane 0
  logic [DATA_WID-1:0] r_ser_data;
  logic                r_ser_valid;
  logic                r_ser_first;
  logic                r_ser_last;
  logic                r_busy;

  logic [NB_W-1:0]     w_neff;
  logic [WORD_W-1:0]   w_ord;
  logic                w_in_ready;
  logic                w_accept;

  // Effective byte count: zero or out-of-range requests mean a full word.
  always_comb begin
    if ((i_in_nbytes == CNT_ZERO) || (i_in_nbytes > CNT_FULL)) begin
      w_neff = CNT_FULL;
    end else begin
      w_neff = i_in_nbytes;
    end
  end

  // Reorder the valid bytes into send order (lane 0 goes out first); unused lanes are zero.
  always_comb begin
    w_ord = WORD_ZERO;
    for (int j = 0; j < WORD_BYTES; j++) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (MSB_FIRST ? ((k + j + 1) == int'(w_neff))
                      : ((k == j) && (j < int'(w_neff)))) begin
          w_ord[j*DATA_WID +: DATA_WID] = w_ord[j*DATA_WID +: DATA_WID]
                                        | i_in_data[k*DATA_WID +: DATA_WID];
        end else begin
          w_ord[j*DATA_WID +: DATA_WID] = w_ord[j*DATA_WID +: DATA_WID];
        end
      end
    end
  end

  // Ready when idle, or while the last byte of the current word is on the output;
  // a pending flush or reset blocks acceptance.
  assign w_in_ready = rst_n & ~i_clr &
                      ((r_state == ST_IDLE) | ((r_state == ST_SHIFT) & (r_cnt == CNT_ONE)));
  assign w_accept   = i_in_valid & w_in_ready;

  // Serializer FSM: load on accept, shift one byte per clock, fall back to idle when done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_shreg     <= WORD_ZERO;
      r_ser_data  <= IDLE_BYTE;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_shreg     <= WORD_ZERO;
      r_ser_data  <= IDLE_BYTE;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (w_accept) begin
            // New word: first byte goes straight to the output, the rest waits in r_shreg.
            r_state     <= ST_SHIFT;
            r_cnt       <= w_neff;
            r_shreg     <= w_ord >> DATA_WID;
            r_ser_data  <= w_ord[DATA_WID-1:0];
            r_ser_valid <= 1'b1;
            r_ser_first <= 1'b1;
            r_ser_last  <= (w_neff == CNT_ONE);
            r_busy      <= 1'b1;
          end else if ((r_state == ST_SHIFT) && (r_cnt != CNT_ONE)) begin
            r_state     <= ST_SHIFT;
            r_cnt       <= r_cnt - CNT_ONE;
            r_shreg     <= r_shreg >> DATA_WID;
            r_ser_data  <= r_shreg[DATA_WID-1:0];
            r_ser_valid <= 1'b1;
            r_ser_first <= 1'b0;
            r_ser_last  <= (r_cnt == CNT_TWO);
            r_busy      <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_shreg     <= WORD_ZERO;
            r_ser_data  <= IDLE_BYTE;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= CNT_ZERO;
          r_shreg     <= WORD_ZERO;
          r_ser_data  <= IDLE_BYTE;
          r_ser_valid <= 1'b0;
          r_ser_first <= 1'b0;
          r_ser_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_ser_data  = r_ser_data;
  assign o_ser_valid = r_ser_valid;
  assign o_ser_first = r_ser_first;
  assign o_ser_last  = r_ser_last;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_piso_byte_serializer.sv
// Bench for piso_byte_serializer: an MSB-first and an LSB-first instance share
// the same stimulus; each has a queue of expected output bytes built from the
// word/byte-count at every accepted handshake.
module tb_piso_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [31:0] i_in_data = 32'h0;
  logic [2:0]  i_in_nbytes = 3'd0;

  logic       m_ready, m_valid, m_first, m_last, m_busy;
  logic [7:0] m_data;
  logic       l_ready, l_valid, l_first, l_last, l_busy;
  logic [7:0] l_data;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         l;
  } ent_t;

  ent_t qm[$];
  ent_t ql[$];
  int   checks = 0;
  int   errors = 0;

  piso_byte_serializer #(.DATA_WID(8), .WORD_BYTES(4), .MSB_FIRST(1'b1), .IDLE_BYTE(8'h00)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_in_valid(i_in_valid), .o_in_ready(m_ready),
    .i_in_data(i_in_data), .i_in_nbytes(i_in_nbytes), .o_ser_data(m_data),
    .o_ser_valid(m_valid), .o_ser_first(m_first), .o_ser_last(m_last), .o_busy(m_busy));

  piso_byte_serializer #(.DATA_WID(8), .WORD_BYTES(4), .MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_in_valid(i_in_valid), .o_in_ready(l_ready),
    .i_in_data(i_in_data), .i_in_nbytes(i_in_nbytes), .o_ser_data(l_data),
    .o_ser_valid(l_valid), .o_ser_first(l_first), .o_ser_last(l_last), .o_busy(l_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The block may take a word when nothing, or only a final byte, is still to be shown.
  function automatic bit exp_ready();
    return (rst_n === 1'b1) && (i_clr === 1'b0) && (qm.size() <= 1);
  endfunction

  task automatic push_word(input logic [31:0] d, input logic [2:0] nb);
    int   n;
    ent_t e;
    n = ((nb == 3'd0) || (nb > 3'd4)) ? 4 : int'(nb);
    for (int j = 0; j < n; j++) begin
      e.f = (j == 0);
      e.l = (j == n - 1);
      e.d = 8'((d >> (8 * (n - 1 - j))) & 32'hFF);
      qm.push_back(e);
      e.d = 8'((d >> (8 * j)) & 32'hFF);
      ql.push_back(e);
    end
  endtask

  task automatic check_one(input string nm, input bit has, input ent_t e,
                           input logic [7:0] sd, input logic sv, input logic sf,
                           input logic sl, input logic bz);
    if (has) begin
      chk({nm, " data"},  32'(sd), 32'(e.d));
      chk({nm, " valid"}, 32'(sv), 32'd1);
      chk({nm, " first"}, 32'(sf), 32'(e.f));
      chk({nm, " last"},  32'(sl), 32'(e.l));
      chk({nm, " busy"},  32'(bz), 32'd1);
    end else begin
      chk({nm, " idle data"},  32'(sd), 32'h00);
      chk({nm, " idle valid"}, 32'(sv), 32'd0);
      chk({nm, " idle first"}, 32'(sf), 32'd0);
      chk({nm, " idle last"},  32'(sl), 32'd0);
      chk({nm, " idle busy"},  32'(bz), 32'd0);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t dummy;
    dummy.d = 8'h00; dummy.f = 1'b0; dummy.l = 1'b0;
    check_one({tag, " msb"}, qm.size() > 0, (qm.size() > 0) ? qm[0] : dummy,
              m_data, m_valid, m_first, m_last, m_busy);
    check_one({tag, " lsb"}, ql.size() > 0, (ql.size() > 0) ? ql[0] : dummy,
              l_data, l_valid, l_first, l_last, l_busy);
    chk({tag, " msb ready"}, 32'(m_ready), 32'(exp_ready()));
    chk({tag, " lsb ready"}, 32'(l_ready), 32'(exp_ready()));
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input string tag, input bit v, input logic [31:0] d,
                       input logic [2:0] nb, input bit c, output bit acc);
    i_in_valid  = v;
    i_in_data   = d;
    i_in_nbytes = nb;
    i_clr       = c;
    #1;
    check_all(tag);
    acc = v && exp_ready();
    @(posedge clk);
    if (qm.size() > 0) qm.delete(0);
    if (ql.size() > 0) ql.delete(0);
    if (c) begin
      qm.delete();
      ql.delete();
    end else if (acc) begin
      push_word(d, nb);
    end
    @(negedge clk);
  endtask

  initial begin
    bit          acc;
    bit          hold;
    bit          v;
    bit          c;
    logic [31:0] d;
    logic [2:0]  nb;
    int          tries;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst data",  32'(m_data),  32'h00);
    chk("rst valid", 32'(m_valid), 32'd0);
    chk("rst ready", 32'(m_ready), 32'd0);
    chk("rst lsb valid", 32'(l_valid), 32'd0);
    rst_n = 1'b1;

    // Full word, nbytes=0 means four bytes
    cycle("w1", 1'b1, 32'hA1B2C3D4, 3'd0, 1'b0, acc);
    chk("w1 accepted", 32'(acc), 32'd1);
    repeat (5) cycle("w1s", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    // Back-to-back words with valid held until each is taken
    cycle("b2b0", 1'b1, 32'h01020304, 3'd4, 1'b0, acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 8) begin
      cycle("b2b1", 1'b1, 32'h05060708, 3'd4, 1'b0, acc);
      tries++;
    end
    chk("b2b second taken", 32'(acc), 32'd1);
    chk("b2b wait cycles", 32'(tries), 32'd4);
    repeat (5) cycle("b2bs", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    // Short words
    cycle("nb2", 1'b1, 32'hFFFF55AA, 3'd2, 1'b0, acc);
    repeat (3) cycle("nb2s", 1'b0, 32'h0, 3'd0, 1'b0, acc);
    cycle("nb1", 1'b1, 32'hFFFF55AA, 3'd1, 1'b0, acc);
    repeat (2) cycle("nb1s", 1'b0, 32'h0, 3'd0, 1'b0, acc);
    cycle("nb7", 1'b1, 32'h89ABCDEF, 3'd7, 1'b0, acc);
    repeat (5) cycle("nb7s", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    // Flush on the second byte, then a clean restart
    cycle("clr0", 1'b1, 32'h11223344, 3'd0, 1'b0, acc);
    cycle("clr1", 1'b0, 32'h0, 3'd0, 1'b0, acc);
    cycle("clr2", 1'b0, 32'h0, 3'd0, 1'b1, acc);
    cycle("clr3", 1'b0, 32'h0, 3'd0, 1'b0, acc);
    cycle("clrbeat", 1'b1, 32'hDEADBEEF, 3'd0, 1'b1, acc);
    chk("clr beats accept", 32'(acc), 32'd0);
    cycle("clrnew", 1'b1, 32'h55667788, 3'd3, 1'b0, acc);
    repeat (4) cycle("clrnews", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    // Asynchronous reset in the middle of a word
    cycle("ar0", 1'b1, 32'hCAFEF00D, 3'd0, 1'b0, acc);
    cycle("ar1", 1'b0, 32'h0, 3'd0, 1'b0, acc);
    rst_n = 1'b0;
    qm.delete();
    ql.delete();
    #1;
    check_all("arst now");
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all("arst held");
    rst_n = 1'b1;
    cycle("ar2", 1'b1, 32'h0BADC0DE, 3'd0, 1'b0, acc);
    repeat (5) cycle("ar2s", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    // Random traffic; a refused word is held until taken
    hold = 1'b0;
    d  = 32'h0;
    nb = 3'd0;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 24) == 0);
      if (hold) begin
        v = 1'b1;
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        d  = $urandom;
        nb = 3'($urandom_range(0, 7));
      end
      cycle("rnd", v, d, nb, c, acc);
      hold = v && !acc && !c;
    end
    repeat (6) cycle("drain", 1'b0, 32'h0, 3'd0, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
